// File: rtl/cpa_seq_pkg.sv
// Shared widths and FSM state type for the sequential 32-bit adder controller.
package cpa_seq_pkg;
  localparam int HALF_W = 16;
  localparam int DATA_W = 2 * HALF_W;
  localparam int RSP_W  = DATA_W + 1;
  localparam int CPA_W  = HALF_W + 1;

  typedef enum logic [1:0] {
    IDLE,
    LO,
    HI,
    DONE
  } state_e;
endpackage

// File: rtl/cpa_17bit.sv
// 17-bit carry-propagate adder slice shared by all requesters; the carry-in
// arrives through bit 0 of both operands.
module cpa_17bit
  import cpa_seq_pkg::*;
(
  input  logic [CPA_W-1:0] x,
  input  logic [CPA_W-1:0] y,
  output logic [CPA_W:0]   sum
);

  assign sum = {1'b0, x} + {1'b0, y};

endmodule

// File: rtl/cpa_seq_add32_ctrl.sv
// Round-robin sequencer running 32-bit adds as two 16-bit passes on one shared
// CPA slice. Define CPA_SEQ_SUB_EN to add the req_sub port and A-B support.
module cpa_seq_add32_ctrl
  import cpa_seq_pkg::*;
#(
  parameter int NREQ = 2
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [NREQ-1:0]           req_valid,
  output logic [NREQ-1:0]           req_ready,
  input  logic [NREQ*DATA_W-1:0]    req_a,
  input  logic [NREQ*DATA_W-1:0]    req_b,
`ifdef CPA_SEQ_SUB_EN
  input  logic [NREQ-1:0]           req_sub,
`endif
  output logic                      rsp_valid,
  input  logic                      rsp_ready,
  output logic [RSP_W-1:0]          rsp_sum,
  output logic [$clog2(NREQ)-1:0]   rsp_id,
  output logic                      busy
);

  localparam int ID_W = $clog2(NREQ);

  state_e            state_q, state_d;
  logic [ID_W-1:0]   rr_ptr_q, rr_ptr_d;
  logic [ID_W-1:0]   rsp_id_q, rsp_id_d;
  logic [DATA_W-1:0] op_a_q, op_a_d;
  logic [DATA_W-1:0] op_b_q, op_b_d;
  logic [HALF_W-1:0] lo_q, lo_d;
  logic              carry_q, carry_d;
  logic              rsp_valid_q, rsp_valid_d;
  logic [RSP_W-1:0]  rsp_sum_q, rsp_sum_d;

  logic [NREQ-1:0]   grant;
  logic [ID_W-1:0]   grant_idx;
  logic              grant_found;
  logic [ID_W:0]     cand;
  logic [DATA_W-1:0] sel_a, sel_b;

  logic              cin, cin_lo;
  logic [HALF_W-1:0] half_a, half_b;
  logic [CPA_W:0]    cpa_sum;
  logic              cpa_lsb_unused;

`ifdef CPA_SEQ_SUB_EN
  logic              sub_q, sub_d;
  logic              sel_sub;
  assign cin_lo = sub_q;
`else
  assign cin_lo = 1'b0;
`endif

  // Search starts one past the last winner so every requester gets a turn.
  always_comb begin
    grant       = '0;
    grant_idx   = '0;
    grant_found = 1'b0;
    cand        = '0;
    for (int k = 1; k <= NREQ; k++) begin
      cand = {1'b0, rr_ptr_q} + (ID_W+1)'(k);
      if (cand >= (ID_W+1)'(NREQ)) begin
        cand = cand - (ID_W+1)'(NREQ);
      end
      if (!grant_found && req_valid[cand[ID_W-1:0]]) begin
        grant_found = 1'b1;
        grant_idx   = cand[ID_W-1:0];
      end
    end
    if (grant_found) begin
      grant[grant_idx] = 1'b1;
    end
  end

  assign req_ready = (state_q == IDLE) ? grant : '0;

  always_comb begin
    sel_a = '0;
    sel_b = '0;
    for (int i = 0; i < NREQ; i++) begin
      if (grant_idx == ID_W'(i)) begin
        sel_a = req_a[i*DATA_W +: DATA_W];
        sel_b = req_b[i*DATA_W +: DATA_W];
      end
    end
  end

`ifdef CPA_SEQ_SUB_EN
  assign sel_sub = req_sub[grant_idx];
`endif

  assign half_a = (state_q == HI) ? op_a_q[DATA_W-1:HALF_W] : op_a_q[HALF_W-1:0];
  assign half_b = (state_q == HI) ? op_b_q[DATA_W-1:HALF_W] : op_b_q[HALF_W-1:0];
  assign cin    = (state_q == HI) ? carry_q : cin_lo;

  cpa_17bit u_cpa (
    .x   ({half_a, cin}),
    .y   ({half_b, cin}),
    .sum (cpa_sum)
  );

  // Bit 0 only absorbs the doubled carry-in and carries no result.
  assign cpa_lsb_unused = cpa_sum[0];

  always_comb begin
    state_d     = state_q;
    rr_ptr_d    = rr_ptr_q;
    rsp_id_d    = rsp_id_q;
    op_a_d      = op_a_q;
    op_b_d      = op_b_q;
    lo_d        = lo_q;
    carry_d     = carry_q;
    rsp_valid_d = rsp_valid_q;
    rsp_sum_d   = rsp_sum_q;
`ifdef CPA_SEQ_SUB_EN
    sub_d       = sub_q;
`endif
    case (state_q)
      IDLE: begin
        if (grant_found) begin
          op_a_d   = sel_a;
`ifdef CPA_SEQ_SUB_EN
          sub_d    = sel_sub;
          op_b_d   = sel_sub ? ~sel_b : sel_b;
`else
          op_b_d   = sel_b;
`endif
          rsp_id_d = grant_idx;
          rr_ptr_d = grant_idx;
          state_d  = LO;
        end
      end
      LO: begin
        lo_d    = cpa_sum[HALF_W:1];
        carry_d = cpa_sum[HALF_W+1];
        state_d = HI;
      end
      HI: begin
        rsp_sum_d   = {cpa_sum[HALF_W+1:1], lo_q};
        rsp_valid_d = 1'b1;
        state_d     = DONE;
      end
      DONE: begin
        if (rsp_ready) begin
          rsp_valid_d = 1'b0;
          state_d     = IDLE;
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= IDLE;
      rr_ptr_q    <= ID_W'(NREQ - 1);
      rsp_id_q    <= '0;
      op_a_q      <= '0;
      op_b_q      <= '0;
      lo_q        <= '0;
      carry_q     <= 1'b0;
      rsp_valid_q <= 1'b0;
      rsp_sum_q   <= '0;
`ifdef CPA_SEQ_SUB_EN
      sub_q       <= 1'b0;
`endif
    end else begin
      state_q     <= state_d;
      rr_ptr_q    <= rr_ptr_d;
      rsp_id_q    <= rsp_id_d;
      op_a_q      <= op_a_d;
      op_b_q      <= op_b_d;
      lo_q        <= lo_d;
      carry_q     <= carry_d;
      rsp_valid_q <= rsp_valid_d;
      rsp_sum_q   <= rsp_sum_d;
`ifdef CPA_SEQ_SUB_EN
      sub_q       <= sub_d;
`endif
    end
  end

  assign rsp_valid = rsp_valid_q;
  assign rsp_sum   = rsp_sum_q;
  assign rsp_id    = rsp_id_q;
  assign busy      = (state_q != IDLE);

endmodule
